// File: rtl/multibyte_adder_pkg.sv
// Purpose : shared types and constants for the byte-serial wide adder.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: state_t (IDLE/ADD/DONE, 2-bit encoding), BYTE_W slice width.
package multibyte_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : multibyte_adder_pkg

// File: rtl/adder_8bit.sv
// Purpose : combinational 8-bit adder slice with carry in/out.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; result follows inputs.
// Ports   : a, b (8b operands), carry_in (1b) -> sum (8b), overflow (carry out).
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       overflow
);

  logic [8:0] w_full;

  assign w_full   = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
  assign sum      = w_full[7:0];
  assign overflow = w_full[8];

endmodule : adder_8bit

// File: rtl/multibyte_serial_adder.sv
// Purpose : adds two NUM_BYTES-wide unsigned operands one byte per clock, LSB first.
// Latency : done pulses NUM_BYTES+1 cycles after the start edge; one op per NUM_BYTES+2 cycles.
// Backpr. : none; start is only accepted in IDLE and silently dropped while busy/done.
// Ports   : clk, n_rst (sync active-low); start, a_in, b_in, carry_in (captured at start);
//           busy (ADD), done (1-cycle), sum_out, overflow (carry out of the MSB byte).
module multibyte_serial_adder
  import multibyte_adder_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic [BYTE_W*NUM_BYTES-1:0] a_in,
  input  logic [BYTE_W*NUM_BYTES-1:0] b_in,
  input  logic                        carry_in,
  output logic                        busy,
  output logic                        done,
  output logic [BYTE_W*NUM_BYTES-1:0] sum_out,
  output logic                        overflow
);

  localparam int                W        = BYTE_W * NUM_BYTES;
  localparam int                IDX_W    = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t             r_state;
  state_t             w_next_state;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_sum;
  logic               r_ovf;

  logic [IDX_W+2:0]   w_bit_ofs;
  logic [BYTE_W-1:0]  w_a_byte;
  logic [BYTE_W-1:0]  w_b_byte;
  logic [BYTE_W-1:0]  w_sum_byte;
  logic               w_carry_out;
  logic               w_last;

  // Byte index times 8, built by concatenation so the width is exact.
  assign w_bit_ofs = {r_idx, 3'b000};
  assign w_a_byte  = r_a[w_bit_ofs +: BYTE_W];
  assign w_b_byte  = r_b[w_bit_ofs +: BYTE_W];
  assign w_last    = (r_idx == LAST_IDX);

  adder_8bit u_adder_8bit (
    .a        (w_a_byte),
    .b        (w_b_byte),
    .carry_in (r_carry),
    .sum      (w_sum_byte),
    .overflow (w_carry_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = ADD;
      ADD:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Status outputs are pure state decodes, so there is no input-to-output path.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ADD:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture in IDLE, one byte of the ripple per ADD cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= carry_in;
            r_idx   <= '0;
            // Drop the previous flag now so it never pairs with the new result.
            r_ovf   <= 1'b0;
          end
        end
        ADD: begin
          r_sum[w_bit_ofs +: BYTE_W] <= w_sum_byte;
          r_carry                    <= w_carry_out;
          r_idx                      <= r_idx + 1'b1;
          if (w_last) begin
            r_ovf <= w_carry_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_out  = r_sum;
  assign overflow = r_ovf;

endmodule : multibyte_serial_adder
